// File: rtl/cacheline_ctrl.sv
// ---------------------------------------------------------------------------
// cacheline_ctrl
//
// Shares one single-word cache line between two requesters and a backing
// memory. Requests are arbitrated round-robin, tag-checked against the line,
// read misses fill the line from memory, and every write is written through
// to memory while also being allocated into the line.
//
// One transaction is in flight at a time:
//   IDLE -> LOOKUP -> RESP                    (read hit)
//   IDLE -> LOOKUP -> MEM_RD -> RESP          (read miss, line fill)
//   IDLE -> LOOKUP -> MEM_WR -> RESP          (write, hit or miss)
//
// Parameters
//   ADDR_W     address / tag width
//   DATA_W     data word width
//
// Ports
//   clock      rising-edge clock
//   reset_n    synchronous active-low reset
//   req_valid  [1:0]          request valid, bit g = requester g
//   req_write  [1:0]          1 = write, 0 = read
//   req_addr   [2*ADDR_W-1:0] requester g at [g*ADDR_W +: ADDR_W]
//   req_wdata  [2*DATA_W-1:0] requester g at [g*DATA_W +: DATA_W]
//   req_ack    [1:0]          combinational grant (accept on valid & ack)
//   rsp_valid  [1:0]          one-cycle response strobe to the granted side
//   rsp_data   [DATA_W-1:0]   read data, or the written data for writes
//   rsp_hit                   request hit the line at lookup
//   flush                     invalidate the line (honoured in IDLE only)
//   mem_req                   memory request, held until mem_ack
//   mem_write                 1 = memory write, 0 = memory read
//   mem_addr   [ADDR_W-1:0]   memory address
//   mem_wdata  [DATA_W-1:0]   memory write data
//   mem_ack                   memory completion (only looked at in MEM_*)
//   mem_rdata  [DATA_W-1:0]   memory read data, valid with mem_ack
// ---------------------------------------------------------------------------
module cacheline_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                clock,
  input  logic                reset_n,

  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          req_ack,

  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_hit,

  input  logic                flush,

  output logic                mem_req,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    MEM_RD = 3'd2,
    MEM_WR = 3'd3,
    RESP   = 3'd4
  } state_e;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e              state_q,      state_d;

  // The cache line itself
  logic                line_valid_q, line_valid_d;
  logic [ADDR_W-1:0]   line_tag_q,   line_tag_d;
  logic [DATA_W-1:0]   line_data_q,  line_data_d;

  // Round-robin history: the requester served by the last completed response
  logic                last_grant_q, last_grant_d;

  // Latched request and response of the transaction in flight
  logic                g_q,          g_d;
  logic [ADDR_W-1:0]   addr_q,       addr_d;
  logic                write_q,      write_d;
  logic [DATA_W-1:0]   wdata_q,      wdata_d;
  logic                hit_q,        hit_d;
  logic [DATA_W-1:0]   data_q,       data_d;

  // -------------------------------------------------------------------------
  // Arbitration: a lone requester wins outright; on a tie the requester that
  // was not served last wins. After reset last_grant_q = 1, so requester 0
  // takes the first tie.
  // -------------------------------------------------------------------------
  logic                grant_any;
  logic                grant_sel;

  always_comb begin
    grant_any = 1'b0;
    grant_sel = 1'b0;
    unique case (req_valid)
      2'b01: begin
        grant_any = 1'b1;
        grant_sel = 1'b0;
      end
      2'b10: begin
        grant_any = 1'b1;
        grant_sel = 1'b1;
      end
      2'b11: begin
        grant_any = 1'b1;
        grant_sel = ~last_grant_q;
      end
      default: ;
    endcase
  end

  // A request is taken only in IDLE and only when no flush is pending,
  // since flush has priority over requests.
  logic accept;
  assign accept = (state_q == IDLE) && !flush && grant_any;

  // Tag check against the line as it stands before any write allocates.
  logic lookup_hit;
  assign lookup_hit = line_valid_q && (line_tag_q == addr_q);

  // Fields of the winning requester.
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_write;

  assign sel_addr  = grant_sel ? req_addr[2*ADDR_W-1:ADDR_W]   : req_addr[ADDR_W-1:0];
  assign sel_wdata = grant_sel ? req_wdata[2*DATA_W-1:DATA_W]  : req_wdata[DATA_W-1:0];
  assign sel_write = grant_sel ? req_write[1]                   : req_write[0];

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register, regardless of order.
  // NOTE: the line is a single word held in flops, not a RAM macro, so it can
  // be cleared by reset along with the rest of the state.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      line_valid_q <= 1'b0;
      line_tag_q   <= '0;
      line_data_q  <= '0;
      last_grant_q <= 1'b1;
      g_q          <= 1'b0;
      addr_q       <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      hit_q        <= 1'b0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      line_valid_q <= line_valid_d;
      line_tag_q   <= line_tag_d;
      line_data_q  <= line_data_d;
      last_grant_q <= last_grant_d;
      g_q          <= g_d;
      addr_q       <= addr_d;
      write_q      <= write_d;
      wdata_q      <= wdata_d;
      hit_q        <= hit_d;
      data_q       <= data_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every signal assigned here starts from a hold/default value so no
  // path through the case statement leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    line_valid_d = line_valid_q;
    line_tag_d   = line_tag_q;
    line_data_d  = line_data_q;
    last_grant_d = last_grant_q;
    g_d          = g_q;
    addr_d       = addr_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    hit_d        = hit_q;
    data_d       = data_q;

    unique case (state_q)
      IDLE: begin
        if (flush) begin
          line_valid_d = 1'b0;
        end else if (accept) begin
          g_d     = grant_sel;
          addr_d  = sel_addr;
          write_d = sel_write;
          wdata_d = sel_wdata;
          state_d = LOOKUP;
        end
      end

      LOOKUP: begin
        hit_d = lookup_hit;
        if (write_q) begin
          // Write-allocate: the line takes the new word now; memory is
          // updated in MEM_WR. rsp_hit still reports the pre-write match.
          line_valid_d = 1'b1;
          line_tag_d   = addr_q;
          line_data_d  = wdata_q;
          state_d      = MEM_WR;
        end else if (lookup_hit) begin
          data_d  = line_data_q;
          state_d = RESP;
        end else begin
          state_d = MEM_RD;
        end
      end

      MEM_RD: begin
        if (mem_ack) begin
          line_valid_d = 1'b1;
          line_tag_d   = addr_q;
          line_data_d  = mem_rdata;
          data_d       = mem_rdata;
          state_d      = RESP;
        end
      end

      MEM_WR: begin
        if (mem_ack) begin
          data_d  = wdata_q;
          state_d = RESP;
        end
      end

      RESP: begin
        last_grant_d = g_q;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // Every output is decoded from the state so that all of them read zero
  // outside the state that owns them, including straight after reset.
  // req_ack is additionally gated by reset_n so nothing looks accepted on an
  // edge that resets the controller.
  always_comb begin
    req_ack   = 2'b00;
    rsp_valid = 2'b00;
    rsp_data  = '0;
    rsp_hit   = 1'b0;
    mem_req   = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    unique case (state_q)
      IDLE: begin
        if (accept && reset_n) begin
          req_ack = grant_sel ? 2'b10 : 2'b01;
        end
      end
      MEM_RD: begin
        mem_req  = 1'b1;
        mem_addr = addr_q;
      end
      MEM_WR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
      end
      RESP: begin
        rsp_valid = g_q ? 2'b10 : 2'b01;
        rsp_data  = data_q;
        rsp_hit   = hit_q;
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Interface properties
  // -------------------------------------------------------------------------
  a_rsp_onehot : assert property (@(posedge clock) disable iff (!reset_n)
    $onehot0(rsp_valid));

  a_ack_onehot : assert property (@(posedge clock) disable iff (!reset_n)
    $onehot0(req_ack));

  a_ack_idle_only : assert property (@(posedge clock) disable iff (!reset_n)
    (req_ack != 2'b00) |-> (state_q == IDLE));

  a_mem_stable : assert property (@(posedge clock) disable iff (!reset_n)
    (mem_req && $past(mem_req) && $past(reset_n))
      |-> ($stable(mem_addr) && $stable(mem_write) && $stable(mem_wdata)));

endmodule

// File: tb/tb_cacheline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cacheline_ctrl
//
// Drives cacheline_ctrl with directed scenarios followed by randomized
// traffic. A transaction-level reference model (line contents, round-robin
// history, and a timeline of the transaction in flight measured in cycles
// since its ack) predicts every output on every cycle; the checker compares
// on the falling edge. Directed scenarios add hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_cacheline_ctrl;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  logic                clock     = 1'b0;
  logic                reset_n   = 1'b0;
  logic [1:0]          req_valid = 2'b00;
  logic [1:0]          req_write = 2'b00;
  logic [2*ADDR_W-1:0] req_addr  = '0;
  logic [2*DATA_W-1:0] req_wdata = '0;
  logic [1:0]          req_ack;
  logic [1:0]          rsp_valid;
  logic [DATA_W-1:0]   rsp_data;
  logic                rsp_hit;
  logic                flush     = 1'b0;
  logic                mem_req;
  logic                mem_write;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_ack   = 1'b0;
  logic [DATA_W-1:0]   mem_rdata = '0;

  cacheline_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ack   (req_ack),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_hit   (rsp_hit),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Memory responder: latency mem_lat cycles (negative = random 0..3).
  // Read data comes from a backing array; junk is driven when not acking.
  // -------------------------------------------------------------------------
  int mem_lat = 0;

  initial begin
    logic [DATA_W-1:0] mem [256];
    int wait_cnt;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[8'h10] = 32'hDEADBEEF;
    wait_cnt = 0;
    forever begin
      @(posedge clock);
      #1;
      if (mem_req && !mem_ack) begin
        if (wait_cnt == 0) begin
          mem_ack = 1'b1;
          if (mem_write) begin
            mem[mem_addr] = mem_wdata;
            mem_rdata     = $urandom;
          end else begin
            mem_rdata = mem[mem_addr];
          end
        end else begin
          wait_cnt--;
          mem_rdata = $urandom;
        end
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        wait_cnt  = (mem_lat < 0) ? int'($urandom_range(3, 0)) : mem_lat;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Reference model and per-cycle checker
  // -------------------------------------------------------------------------
  logic [1:0]        acc_s   = 2'b00;  // requests accepted at the coming edge
  int                neg_cnt = 0;
  int                ack_neg = 0;
  bit                mdl_ok  = 1'b0;

  bit                m_valid, m_last;
  logic [ADDR_W-1:0] m_tag;
  logic [DATA_W-1:0] m_data;

  bit                busy, t_g, t_write, t_hit, t_need_mem, t_mem_done, t_rsp_now;
  int                t_age;
  logic [ADDR_W-1:0] t_addr;
  logic [DATA_W-1:0] t_wdata, t_data;
  logic [1:0]        e_ack;

  function automatic logic [1:0] arb(input logic [1:0] v, input bit fl, input bit last);
    if (fl || v == 2'b00) return 2'b00;
    if (v == 2'b11)       return last ? 2'b01 : 2'b10;
    return v;
  endfunction

  always @(negedge clock) begin
    neg_cnt++;
    acc_s = req_valid & req_ack;
    if (acc_s != 2'b00) ack_neg = neg_cnt;
    e_ack = 2'b00;

    if (mdl_ok) begin
      e_ack = (!busy && reset_n) ? arb(req_valid, flush, m_last) : 2'b00;
      check("req_ack", req_ack, e_ack);

      if (busy && t_rsp_now) begin
        check("rsp_valid", rsp_valid, t_g ? 2'b10 : 2'b01);
        check("rsp_data",  rsp_data,  t_data);
        check("rsp_hit",   rsp_hit,   t_hit);
      end else begin
        check("rsp_valid idle", rsp_valid, 2'b00);
      end

      if (busy && t_need_mem && t_age >= 2 && !t_mem_done) begin
        check("mem_req",   mem_req,   1'b1);
        check("mem_write", mem_write, t_write);
        check("mem_addr",  mem_addr,  t_addr);
        if (t_write) check("mem_wdata", mem_wdata, t_wdata);
      end else begin
        check("mem_req idle", mem_req, 1'b0);
      end
    end

    // Advance the model to the state after the coming rising edge.
    if (!reset_n) begin
      mdl_ok  = 1'b1;
      m_valid = 1'b0;
      m_tag   = '0;
      m_data  = '0;
      m_last  = 1'b1;
      busy    = 1'b0;
    end else if (mdl_ok) begin
      if (!busy) begin
        if (flush) begin
          m_valid = 1'b0;
        end else if (e_ack != 2'b00) begin
          t_g        = (e_ack == 2'b10);
          t_write    = req_write[t_g];
          t_addr     = req_addr[t_g*ADDR_W +: ADDR_W];
          t_wdata    = req_wdata[t_g*DATA_W +: DATA_W];
          t_hit      = m_valid && (m_tag == t_addr);
          t_need_mem = t_write || !t_hit;
          t_mem_done = 1'b0;
          t_rsp_now  = 1'b0;
          t_age      = 1;
          busy       = 1'b1;
          if (t_write) begin
            m_valid = 1'b1;
            m_tag   = t_addr;
            m_data  = t_wdata;
          end else if (t_hit) begin
            t_data = m_data;
          end
        end
      end else if (t_rsp_now) begin
        busy   = 1'b0;
        m_last = t_g;
      end else begin
        if (!t_need_mem && t_age == 1) begin
          t_rsp_now = 1'b1;
        end else if (t_need_mem && t_age >= 2 && mem_ack) begin
          t_mem_done = 1'b1;
          t_rsp_now  = 1'b1;
          if (t_write) begin
            t_data = t_wdata;
          end else begin
            t_data  = mem_rdata;
            m_valid = 1'b1;
            m_tag   = t_addr;
            m_data  = mem_rdata;
          end
        end
        t_age++;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers (inputs change only just after a rising edge)
  // -------------------------------------------------------------------------
  task automatic step();
    @(posedge clock);
    #1;
    req_valid = req_valid & ~acc_s;
  endtask

  task automatic issue(input bit g, input logic wr, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d);
    req_write[g]                  = wr;
    req_addr[g*ADDR_W +: ADDR_W]  = a;
    req_wdata[g*DATA_W +: DATA_W] = d;
    req_valid[g]                  = 1'b1;
  endtask

  task automatic wait_mem(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      step();
      @(negedge clock);
      #1;
      if (mem_req) seen = 1'b1;
    end
    if (!seen) check({tag, " mem_req timeout"}, 1, 0);
  endtask

  task automatic wait_rsp(input string tag, output logic [1:0] v, output logic [DATA_W-1:0] d,
                          output logic h, output int lat, output bit saw_mem);
    v = 2'b00; d = '0; h = 1'b0; lat = -1; saw_mem = 1'b0;
    for (int i = 0; i < 60 && lat < 0; i++) begin
      step();
      @(negedge clock);
      #1;
      if (mem_req) saw_mem = 1'b1;
      if (rsp_valid != 2'b00) begin
        v   = rsp_valid;
        d   = rsp_data;
        h   = rsp_hit;
        lat = neg_cnt - ack_neg;
      end
    end
    if (lat < 0) check({tag, " rsp timeout"}, 1, 0);
    step();
  endtask

  // -------------------------------------------------------------------------
  // Main sequence
  // -------------------------------------------------------------------------
  initial begin
    logic [1:0]        v;
    logic [DATA_W-1:0] d;
    logic              h;
    int                lat;
    bit                sm;
    int                order[$];
    logic [ADDR_W-1:0] pool [5];

    pool = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};

    // Reset: every output zero.
    reset_n = 1'b0;
    repeat (3) step();
    @(negedge clock); #1;
    check("reset req_ack",   req_ack,   2'b00);
    check("reset rsp_valid", rsp_valid, 2'b00);
    check("reset rsp_data",  rsp_data,  0);
    check("reset rsp_hit",   rsp_hit,   0);
    check("reset mem_req",   mem_req,   0);
    check("reset mem_write", mem_write, 0);
    check("reset mem_addr",  mem_addr,  0);
    check("reset mem_wdata", mem_wdata, 0);
    step();
    reset_n = 1'b1;

    // Read miss on 0x10, memory answers after two wait cycles.
    mem_lat = 2;
    issue(1'b0, 1'b0, 8'h10, '0);
    wait_mem("t1");
    check("t1 mem_write", mem_write, 0);
    check("t1 mem_addr",  mem_addr,  8'h10);
    wait_rsp("t1", v, d, h, lat, sm);
    check("t1 rsp_valid", v,   2'b01);
    check("t1 rsp_data",  d,   32'hDEADBEEF);
    check("t1 rsp_hit",   h,   0);
    check("t1 latency",   lat, 5);

    // Same address again: hit, response two cycles after the ack.
    issue(1'b0, 1'b0, 8'h10, '0);
    wait_rsp("t2", v, d, h, lat, sm);
    check("t2 rsp_valid", v,   2'b01);
    check("t2 rsp_data",  d,   32'hDEADBEEF);
    check("t2 rsp_hit",   h,   1);
    check("t2 latency",   lat, 2);
    check("t2 no mem",    sm,  0);

    // Requester 1 writes 0x20, then reads hit it, then 0x10 misses.
    mem_lat = 1;
    issue(1'b1, 1'b1, 8'h20, 32'h12345678);
    wait_mem("t3w");
    check("t3w mem_write", mem_write, 1);
    check("t3w mem_addr",  mem_addr,  8'h20);
    check("t3w mem_wdata", mem_wdata, 32'h12345678);
    wait_rsp("t3w", v, d, h, lat, sm);
    check("t3w rsp_valid", v, 2'b10);
    check("t3w rsp_data",  d, 32'h12345678);
    check("t3w rsp_hit",   h, 0);
    issue(1'b0, 1'b0, 8'h20, '0);
    wait_rsp("t3r", v, d, h, lat, sm);
    check("t3r rsp_data", d,  32'h12345678);
    check("t3r rsp_hit",  h,  1);
    check("t3r no mem",   sm, 0);
    issue(1'b0, 1'b0, 8'h10, '0);
    wait_rsp("t3m", v, d, h, lat, sm);
    check("t3m rsp_hit",  h,  0);
    check("t3m mem used", sm, 1);
    check("t3m rsp_data", d,  32'hDEADBEEF);

    // Both requesters valid from reset, zero-wait memory: strict alternation.
    mem_lat = 0;
    reset_n = 1'b0;
    issue(1'b0, 1'b0, 8'h30, '0);
    issue(1'b1, 1'b0, 8'h40, '0);
    repeat (2) step();
    reset_n = 1'b1;
    for (int i = 0; i < 200 && order.size() < 8; i++) begin
      @(negedge clock); #1;
      if (acc_s != 2'b00) order.push_back(int'(acc_s == 2'b10));
      step();
      if (!req_valid[0]) issue(1'b0, 1'b0, 8'h30, '0);
      if (!req_valid[1]) issue(1'b1, 1'b0, 8'h40, '0);
    end
    check("t4 ack count", order.size(), 8);
    for (int i = 0; i < order.size(); i++) check($sformatf("t4 ack order %0d", i), order[i], i % 2);
    repeat (30) step();

    // Flush wins over a simultaneous request and invalidates the line.
    mem_lat = 1;
    issue(1'b0, 1'b0, 8'h50, '0);
    wait_rsp("t5fill", v, d, h, lat, sm);
    flush = 1'b1;
    issue(1'b0, 1'b0, 8'h50, '0);
    @(negedge clock); #1;
    check("t5 ack under flush", req_ack, 2'b00);
    step();
    flush = 1'b0;
    wait_rsp("t5", v, d, h, lat, sm);
    check("t5 rsp_hit",   h,  0);
    check("t5 mem used",  sm, 1);
    check("t5 rsp_valid", v,  2'b01);

    // Reset while in MEM_RD abandons the transaction and the line.
    issue(1'b0, 1'b0, 8'h60, '0);
    wait_rsp("t6fill", v, d, h, lat, sm);
    mem_lat = 20;
    issue(1'b0, 1'b0, 8'h70, '0);
    wait_mem("t6");
    step();
    reset_n = 1'b0;
    step();
    @(negedge clock); #1;
    check("t6 mem_req after reset",   mem_req,   0);
    check("t6 rsp_valid after reset", rsp_valid, 2'b00);
    step();
    reset_n = 1'b1;
    mem_lat = 1;
    issue(1'b0, 1'b0, 8'h60, '0);
    wait_rsp("t6", v, d, h, lat, sm);
    check("t6 rsp_hit",  h,  0);
    check("t6 mem used", sm, 1);

    // Randomized traffic with flushes, occasional resets and random latency.
    mem_lat = -1;
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int g = 0; g < 2; g++) begin
        if (!req_valid[g] && $urandom_range(99, 0) < 30)
          issue(g[0], 1'($urandom_range(1, 0)), pool[$urandom_range(4, 0)], $urandom);
      end
      flush   = ($urandom_range(99, 0) < 4);
      reset_n = ($urandom_range(499, 0) != 0);
    end
    flush   = 1'b0;
    reset_n = 1'b1;
    repeat (60) step();
    check("drain all served", req_valid, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cacheline_ctrl.md
# cacheline_ctrl

Controller that shares a single one-word cache line between two requesters and a backing memory. Arbitrates round-robin, performs the tag check, fills the line on read miss, and writes through on every write (write-allocate). Embeds the line state (valid, tag, data) and presents one request/response handshake per requester plus a single-outstanding memory handshake.

## Interface
- `ADDR_W`, default 8: address and tag width.
- `DATA_W`, default 32: data word width.

- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  2  per-requester request valid; bit g = requester g.
- `req_write`  in  2  per-requester write (1) / read (0).
- `req_addr`  in  2*ADDR_W  requester g at `[g*ADDR_W +: ADDR_W]`.
- `req_wdata`  in  2*DATA_W  requester g at `[g*DATA_W +: DATA_W]`.
- `req_ack`  out  2  combinational grant; request accepted on the edge where `req_valid[g] & req_ack[g]`.
- `rsp_valid`  out  2  one-cycle response strobe to the granted requester.
- `rsp_data`  out  DATA_W  read data (reads) or written data (writes); valid while `rsp_valid` is nonzero.
- `rsp_hit`  out  1  1 if the request hit the line at lookup.
- `flush`  in  1  invalidate request; honoured only in IDLE.
- `mem_req`  out  1  memory access request, held until `mem_ack`.
- `mem_write`  out  1  memory write (1) / read (0).
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_ack`  in  1  memory completion; sampled only while `mem_req` = 1.
- `mem_rdata`  in  DATA_W  read data, valid on the `mem_ack` cycle.

## Operation
- States: IDLE, LOOKUP, MEM_RD, MEM_WR, RESP.
- Internal state: `line_valid`, `line_tag[ADDR_W]`, `line_data[DATA_W]`, `last_grant` (1 bit), latched `g`, `addr`, `write`, `wdata`, `hit`.
- IDLE:
  - If `flush` = 1: clear `line_valid`, no `req_ack`, stay IDLE. Flush has priority over requests.
  - Else if any `req_valid`: grant g.
    - Single requester: g is that requester.
    - Both valid: g = `~last_grant`.
  - `req_ack[g]` = 1 combinationally; latch the request; go to LOOKUP.
- LOOKUP:
  - `hit` = `line_valid & (line_tag == addr)`.
  - Read hit: data = `line_data`; go to RESP.
  - Read miss: go to MEM_RD.
  - Write, hit or miss: set `line_valid`=1, `line_tag`=addr, `line_data`=wdata at this edge; go to MEM_WR.
- MEM_RD: `mem_req`=1, `mem_write`=0, `mem_addr`=addr.
  - On `mem_ack`: fill the line (valid=1, tag=addr, data=`mem_rdata`), capture the response data, go to RESP.
- MEM_WR: `mem_req`=1, `mem_write`=1, `mem_addr`=addr, `mem_wdata`=wdata.
  - On `mem_ack`: go to RESP; response data = wdata.
- RESP: `rsp_valid[g]`=1, `rsp_data`, `rsp_hit`=hit; `last_grant` ← g; go to IDLE.
- Requesters hold `req_valid` and all request fields stable until acked. Unacked requests persist.
- `mem_*` outputs are stable for the whole MEM_RD/MEM_WR stay. `mem_ack` outside MEM_RD/MEM_WR is ignored.
- `rsp_hit` for a write reflects the pre-write tag match.

## Timing
- Reset (`reset_n`=0 at an edge): state=IDLE, `line_valid`=0, tag/data=0, `last_grant`=1 (requester 0 wins the first tie).
  - All outputs 0 after that edge: `req_ack`, `rsp_valid`, `rsp_data`, `rsp_hit`, `mem_req`, `mem_write`, `mem_addr`, `mem_wdata`.
- Reset mid-transaction abandons it: no `rsp_valid` is issued, and `mem_req` drops after the reset edge. Memory must tolerate a withdrawn request.
- Read hit, counting the ack edge as edge 0: LOOKUP in cycle 1, `rsp_valid` high in cycle 2. Next ack no earlier than edge 3.
- Miss or write: MEM state entered at edge 1; `mem_req` high from cycle 2.
  - If `mem_ack` = 1 at edge k, `rsp_valid` is high in cycle k+1.
  - Zero-wait `mem_ack` (sampled at the first MEM-state edge) is legal.
- Single outstanding transaction; no pipelining; at most one `rsp_valid` bit set at any time.

## Test plan
- Reset, then req0 reads 0x10 -> `mem_req`=1, `mem_write`=0, `mem_addr`=0x10. Memory acks 2 cycles later with 0xDEADBEEF -> `rsp_valid`=2'b01, `rsp_data`=0xDEADBEEF, `rsp_hit`=0.
- req0 reads 0x10 again -> no `mem_req`; `rsp_valid[0]` in cycle 2 after ack, data 0xDEADBEEF, `rsp_hit`=1.
- req1 writes 0x20 = 0x12345678 -> memory write to 0x20 with that data, `rsp_hit`=0. Read 0x20 -> hit, 0x12345678. Read 0x10 -> miss.
- Both requesters hold `req_valid` continuously from reset, with zero-wait memory -> acks alternate 0,1,0,1; none starved.
- `flush` and `req_valid[0]` both asserted in IDLE -> no ack that cycle, line invalidated. Next read of the cached address -> `rsp_hit`=0 with a memory read.
- `reset_n`=0 while in MEM_RD -> `mem_req`=0 after the reset edge, no `rsp_valid`. Subsequent read of the previously filled address misses.
